// File: rtl/cook_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cook_pkg                                                     |
// | Description : Shared types and constants for the microwave cook sequencer. |
// |               COOK_RECIPE_EN adds the recipe-store configuration state.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cook_pkg;

    localparam int KEY_START    = 10;
    localparam int KEY_CANCEL   = 11;
    localparam int c_num_digits = 10;
    localparam int c_num_slots  = 4;
    localparam int c_time_w     = 16;
    localparam logic [c_time_w-1:0] c_time_zero = '0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_RUN      = 3'd2,
        S_PAUSE    = 3'd3,
        S_DONE     = 3'd4,
        S_CFG_WAIT = 3'd5,
        S_CFG_CLK  = 3'd6
`ifdef COOK_RECIPE_EN
        ,
        S_CFG_REC  = 3'd7
`endif
    } state_t;

    // Single winning key event per cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_CANCEL = 3'd1,
        EV_START  = 3'd2,
        EV_CONF   = 3'd3,
        EV_REC    = 3'd4,
        EV_DIGIT  = 3'd5
    } event_t;

    // New digit enters at the minutes-tens position; the seconds-units digit falls off.
    function automatic logic [c_time_w-1:0] shift_digit(input logic [c_time_w-1:0] cur,
                                                         input logic [3:0]          digit);
        return {digit, cur[c_time_w-1:4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cook_sequencer_bcd_mmss_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_mmss_dec                                                 |
// | Description : Combinational one-second decrement of a BCD MM:SS value.     |
// |               Seconds may hold up to 99; SS=00 borrows a minute -> SS=59.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_mmss_dec
    import cook_pkg::*;
(
    input  logic [c_time_w-1:0] i_mmss,
    output logic [c_time_w-1:0] o_dec,
    output logic                zero
);

    logic [3:0] w_d3, w_d2, w_d1, w_d0;

    assign {w_d3, w_d2, w_d1, w_d0} = i_mmss;

    // Borrow ripples from the lowest non-zero digit; 00:00 saturates.
    always_comb begin
        o_dec = i_mmss;
        if (i_mmss == c_time_zero)
            o_dec = c_time_zero;
        else if (w_d0 != 4'd0)
            o_dec = {w_d3, w_d2, w_d1, w_d0 - 4'd1};
        else if (w_d1 != 4'd0)
            o_dec = {w_d3, w_d2, w_d1 - 4'd1, 4'd9};
        else if (w_d2 != 4'd0)
            o_dec = {w_d3, w_d2 - 4'd1, 4'd5, 4'd9};
        else
            o_dec = {w_d3 - 4'd1, 4'd9, 4'd5, 4'd9};
    end

    assign zero = (o_dec == c_time_zero);

endmodule
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cook_sequencer                                               |
// | Description : Microwave cooking-cycle controller: time entry, countdown,   |
// |               pause/resume, done beep, clock set and (with the macro       |
// |               COOK_RECIPE_EN) four recipe preset slots.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int BEEP_SEC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [11:0]         t,
    input  logic                conf,
    input  logic [3:0]          r,
    input  logic                porta,
    output logic [c_time_w-1:0] disp_bcd,
    output logic                disp_cook,
    output logic                clk_set,
    output logic [c_time_w-1:0] clk_set_bcd,
    output logic                luz,
    output logic                motor,
    output logic                aquec,
    output logic                som
);

    localparam int c_beep_w = (BEEP_SEC < 2) ? 1 : $clog2(BEEP_SEC + 1);

    state_t                r_state, w_state_n;
    logic [c_time_w-1:0]   r_buf, w_buf_n;
    logic [11:0]           r_t_q;
    logic                  r_conf_q;
    logic [1:0]            r_cnt, w_cnt_n;
    logic [c_beep_w-1:0]   r_beep, w_beep_n;
    logic                  w_clk_set_n;
    logic [11:0]           w_t_press;
    logic                  w_conf_press;
    logic [3:0]            w_r_press;
    event_t                w_ev;
    logic [3:0]            w_ev_val;
    logic [c_time_w-1:0]   w_dec;
    logic                  w_dec_zero;
    logic [c_time_w-1:0]   w_slot_val;

    assign w_t_press    = t & ~r_t_q;
    assign w_conf_press = conf & ~r_conf_q;

`ifdef COOK_RECIPE_EN
    logic [3:0]            r_r_q;
    logic [1:0]            r_slot_idx, w_slot_idx_n;
    logic                  w_slot_we;
    logic [c_time_w-1:0]   r_slots [c_num_slots];

    assign w_r_press  = r & ~r_r_q;
    assign w_slot_val = r_slots[w_ev_val[1:0]];

    // Recipe slot storage and the r edge register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_q      <= '0;
            r_slot_idx <= '0;
            for (int i = 0; i < c_num_slots; i++)
                r_slots[i] <= c_time_zero;
        end else begin
            r_r_q      <= r;
            r_slot_idx <= w_slot_idx_n;
            if (w_slot_we)
                r_slots[r_slot_idx] <= w_buf_n;
        end
    end
`else
    logic w_unused_r;

    assign w_unused_r = ^r;
    assign w_r_press  = '0;
    assign w_slot_val = c_time_zero;
`endif

    bcd_mmss_dec u_dec (
        .i_mmss (r_buf),
        .o_dec  (w_dec),
        .zero   (w_dec_zero)
    );

    // Resolve simultaneous presses: cancel > start > conf > lowest recipe > lowest digit.
    always_comb begin
        w_ev     = EV_NONE;
        w_ev_val = 4'd0;
        if (w_t_press[KEY_CANCEL])
            w_ev = EV_CANCEL;
        else if (w_t_press[KEY_START])
            w_ev = EV_START;
        else if (w_conf_press)
            w_ev = EV_CONF;
        else if (|w_r_press) begin
            w_ev = EV_REC;
            for (int k = c_num_slots - 1; k >= 0; k--)
                if (w_r_press[k]) w_ev_val = 4'(k);
        end else if (|w_t_press[c_num_digits-1:0]) begin
            w_ev = EV_DIGIT;
            for (int k = c_num_digits - 1; k >= 0; k--)
                if (w_t_press[k]) w_ev_val = 4'(k);
        end
    end

    // Next-state, time buffer, beep and configuration bookkeeping.
    always_comb begin
        w_state_n   = r_state;
        w_buf_n     = r_buf;
        w_cnt_n     = r_cnt;
        w_beep_n    = r_beep;
        w_clk_set_n = 1'b0;
`ifdef COOK_RECIPE_EN
        w_slot_idx_n = r_slot_idx;
        w_slot_we    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_ev == EV_DIGIT) begin
                    w_buf_n   = shift_digit(c_time_zero, w_ev_val);
                    w_state_n = S_ENTRY;
                end else if (w_ev == EV_REC) begin
                    w_buf_n   = w_slot_val;
                    w_state_n = S_ENTRY;
                end else if (w_ev == EV_CONF)
                    w_state_n = S_CFG_WAIT;
            end
            S_ENTRY: begin
                if (w_ev == EV_DIGIT)
                    w_buf_n = shift_digit(r_buf, w_ev_val);
                else if (w_ev == EV_REC)
                    w_buf_n = w_slot_val;
                else if (w_ev == EV_START) begin
                    if (r_buf != c_time_zero && !porta)
                        w_state_n = S_RUN;
                end else if (w_ev == EV_CANCEL) begin
                    w_buf_n   = c_time_zero;
                    w_state_n = S_IDLE;
                end
            end
            S_RUN: begin
                // Door or cancel wins over a coincident tick: the time is held.
                if (porta || w_ev == EV_CANCEL)
                    w_state_n = S_PAUSE;
                else if (tick) begin
                    w_buf_n = w_dec;
                    if (w_dec_zero) begin
                        w_state_n = S_DONE;
                        w_beep_n  = c_beep_w'(BEEP_SEC);
                    end
                end
            end
            S_PAUSE: begin
                if (w_ev == EV_START && !porta)
                    w_state_n = S_RUN;
                else if (w_ev == EV_CANCEL) begin
                    w_buf_n   = c_time_zero;
                    w_state_n = S_IDLE;
                end
            end
            S_DONE: begin
                if (w_ev != EV_NONE)
                    w_state_n = S_IDLE;
                else if (tick) begin
                    w_beep_n = r_beep - c_beep_w'(1);
                    if (r_beep <= c_beep_w'(1))
                        w_state_n = S_IDLE;
                end
            end
            S_CFG_WAIT: begin
`ifdef COOK_RECIPE_EN
                if (w_ev == EV_REC) begin
                    w_slot_idx_n = w_ev_val[1:0];
                    w_buf_n      = c_time_zero;
                    w_cnt_n      = 2'd0;
                    w_state_n    = S_CFG_REC;
                end else
`endif
                if (w_ev == EV_DIGIT) begin
                    w_buf_n   = shift_digit(c_time_zero, w_ev_val);
                    w_cnt_n   = 2'd1;
                    w_state_n = S_CFG_CLK;
                end else if (w_ev == EV_CANCEL)
                    w_state_n = S_IDLE;
            end
            S_CFG_CLK: begin
                if (w_ev == EV_DIGIT) begin
                    w_buf_n = shift_digit(r_buf, w_ev_val);
                    w_cnt_n = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_clk_set_n = 1'b1;
                        w_state_n   = S_IDLE;
                    end
                end else if (w_ev == EV_CANCEL)
                    w_state_n = S_IDLE;
            end
`ifdef COOK_RECIPE_EN
            S_CFG_REC: begin
                if (w_ev == EV_DIGIT) begin
                    w_buf_n = shift_digit(r_buf, w_ev_val);
                    w_cnt_n = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_slot_we = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end else if (w_ev == EV_CANCEL)
                    w_state_n = S_IDLE;
            end
`endif
            default: w_state_n = S_IDLE;
        endcase
    end

    // State, edge registers and outputs decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= c_time_zero;
            r_t_q       <= '0;
            r_conf_q    <= 1'b0;
            r_cnt       <= 2'd0;
            r_beep      <= '0;
            disp_cook   <= 1'b0;
            clk_set     <= 1'b0;
            clk_set_bcd <= c_time_zero;
            luz         <= 1'b0;
            motor       <= 1'b0;
            aquec       <= 1'b0;
            som         <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_buf       <= w_buf_n;
            r_t_q       <= t;
            r_conf_q    <= conf;
            r_cnt       <= w_cnt_n;
            r_beep      <= w_beep_n;
            disp_cook   <= (w_state_n != S_IDLE);
            clk_set     <= w_clk_set_n;
            if (w_clk_set_n)
                clk_set_bcd <= w_buf_n;
            luz         <= (w_state_n == S_RUN) || porta;
            motor       <= (w_state_n == S_RUN);
            aquec       <= (w_state_n == S_RUN);
            som         <= (w_state_n == S_DONE);
        end
    end

    assign disp_bcd = r_buf;

endmodule
`default_nettype wire
